// File: rtl/clap_timer_bank.sv
// clap_timer_bank: bank of independent stopwatch channels with a
// restart, count-enable and capture-and-freeze ("clap") input per channel.
module clap_timer_bank #(
    parameter int WIDTH    = 17,
    parameter int MAXCOUNT = 66080,
    parameter int CHANNELS = 2,
    parameter int WRAP     = 0
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [CHANNELS-1:0]       go,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       stop,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS*WIDTH-1:0] capture,
    output logic [CHANNELS-1:0]       cap_valid,
    output logic [CHANNELS-1:0]       expired,
    output logic [CHANNELS-1:0]       wrapped,
    output logic [CHANNELS-1:0]       running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] TERM = WIDTH'(MAXCOUNT);

    if (MAXCOUNT < 1 || longint'(MAXCOUNT) >= (longint'(1) << WIDTH)
        || CHANNELS < 1) begin : g_bad_params
        $error("clap_timer_bank: illegal MAXCOUNT/WIDTH/CHANNELS");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           state, state_n;
        logic [WIDTH-1:0] cnt, cnt_n;
        logic [WIDTH-1:0] cap, cap_n;
        logic             cv_q, cv_n;
        logic             exp_q, exp_n;
        logic             wrap_q, wrap_n;

        // go overrides everything; stop beats the terminal condition
        always_comb begin
            state_n = state;
            cnt_n   = cnt;
            cap_n   = cap;
            cv_n    = 1'b0;
            exp_n   = exp_q;
            wrap_n  = 1'b0;
            if (go[i]) begin
                state_n = RUN;
                cnt_n   = '0;
                exp_n   = 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (stop[i]) begin
                            cap_n   = cnt;
                            cv_n    = 1'b1;
                            state_n = HOLD;
                        end else if (en[i]) begin
                            if (cnt == TERM) begin
                                if (WRAP != 0) begin
                                    cnt_n  = '0;
                                    wrap_n = 1'b1;
                                end else begin
                                    state_n = HOLD;
                                    exp_n   = 1'b1;
                                end
                            end else begin
                                cnt_n = cnt + WIDTH'(1);
                            end
                        end
                    end
                    IDLE, HOLD: ;
                    default: state_n = IDLE;
                endcase
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state  <= IDLE;
                cnt    <= '0;
                cap    <= '0;
                cv_q   <= 1'b0;
                exp_q  <= 1'b0;
                wrap_q <= 1'b0;
            end else begin
                state  <= state_n;
                cnt    <= cnt_n;
                cap    <= cap_n;
                cv_q   <= cv_n;
                exp_q  <= exp_n;
                wrap_q <= wrap_n;
            end
        end

        assign count[i*WIDTH +: WIDTH]   = cnt;
        assign capture[i*WIDTH +: WIDTH] = cap;
        assign cap_valid[i]              = cv_q;
        assign expired[i]                = exp_q;
        assign wrapped[i]                = wrap_q;
        assign running[i]                = (state == RUN);
    end

endmodule
